vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the vga_if pipeline: generates XGA 1024x768@60 timing (hcount, vcount,
//  hsync, vsync, hblnk, vblnk) from clk65MHz. Drives the first vga_if.out, which feeds
//  draw_bg -> draw_rect -> draw_mouse. rgb is driven black; later stages overwrite it.
//  Also emits single-cycle line/frame strobes for per-frame logic (mouse position latch).
// PARAMETERS
//  H_ACTIVE    1024  visible pixels per line
//  H_FP        24    horizontal front porch (pixels)
//  H_SYNC      136   hsync width (pixels)
//  H_TOTAL     1344  total pixels per line
//  V_ACTIVE    768   visible lines per frame
//  V_FP        3     vertical front porch (lines)
//  V_SYNC      6     vsync width (lines)
//  V_TOTAL     806   total lines per frame
// PORTS
//  clk65MHz     in   1    pixel clock, 65 MHz
//  rst          in   1    synchronous reset, active-high
//  vga_out_if   vga_if.out  hcount/vcount 11b, hsync/vsync/hblnk/vblnk 1b, rgb 12b
//  line_start   out  1    high for the cycle in which vga_out_if.hcount == 0
//  frame_start  out  1    high for the cycle in which hcount == 0 and vcount == 0
// BEHAVIOUR
//  - Single clock, synchronous active-high reset. All outputs registered, no comb paths.
//  - Reset: hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, rgb=0,
//    line_start=0, frame_start=0. Reset state represents pixel (0,0) minus strobes.
//  - First edge with rst=0 -> hcount=1, vcount=0. Every output field always describes
//    the hcount/vcount presented in the same cycle (decode from next-count values).
//  - hcount: 0..H_TOTAL-1, +1 per clock; at H_TOTAL-1 wraps to 0 and vcount advances.
//  - vcount: 0..V_TOTAL-1; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0 on the same edge.
//  - hblnk = (hcount >= H_ACTIVE); vblnk = (vcount >= V_ACTIVE).
//  - hsync = (hcount >= H_ACTIVE+H_FP) && (hcount < H_ACTIVE+H_FP+H_SYNC): 1048..1183.
//  - vsync = (vcount >= V_ACTIVE+V_FP) && (vcount < V_ACTIVE+V_FP+V_SYNC): 771..776.
//  - Sync levels are active-high on vga_if; pad polarity is inverted at top level.
//  - rgb = 12'h000 at all times.
//  - line_start/frame_start: 1-cycle pulses, not asserted in reset or on the first
//    cycle after release; first frame_start is H_TOTAL*V_TOTAL cycles after release.
//  - Reset mid-frame: next edge returns to the reset state regardless of counters.
//  - Counters are 11 bits; no value >= H_TOTAL / V_TOTAL is ever produced.
//  - Period: 1344 clocks/line, 1083264 clocks/frame (~60.0 Hz at 65 MHz).
// STRUCTURE
//  - XGA constants (H_*, V_*) and COUNT_W=11 go in vga_pkg; parameter defaults use them.
//  - vga_if unchanged. One natural sub-module: wrap_counter (WIDTH, MAX; inc in, count
//    out, wrap out), instantiated twice; hcount wrap drives vcount inc. Decode in top.
// TESTING
//  - Reset 5 cycles, release -> cycle 1: hcount=1, vcount=0, all flags 0, rgb=0.
//  - Run 1 line -> hblnk rises at hcount=1024; hsync high exactly for 1048..1183 (136
//    clk); hcount 1343 -> 0 with vcount 0 -> 1 on the same edge; line_start at hcount=0.
//  - Run 1 frame -> vblnk from vcount=768; vsync high for vcount 771..776 (6*1344 clk);
//    (1343,805) -> (0,0); frame_start one pulse, 1083264 cycles after release.
//  - Assert rst at (500,400) for 1 cycle -> next cycle all outputs at reset values,
//    then counting restarts from hcount=1.
//  - 3 frames, scoreboard vs reference model -> fields match each cycle; hcount<1344,
//    vcount<806 always; frame_start count = 3, line_start count = 3*806.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : XGA 1024x768@60 timing constants and counter width
// Revision: 1.0
// ============================================================================
package vga_pkg;

  localparam int COUNT_W  = 11;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_TOTAL  = 1344;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_TOTAL  = 806;

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
// vga_if : pixel-stream bundle passed between the vga pipeline stages
// Revision: 1.0
// ============================================================================
interface vga_if;
  import vga_pkg::*;

  logic [COUNT_W-1:0] hcount;
  logic [COUNT_W-1:0] vcount;
  logic               hsync;
  logic               vsync;
  logic               hblnk;
  logic               vblnk;
  logic [11:0]        rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen_wrap_counter.sv
`default_nettype none
// ============================================================================
// wrap_counter : 0..MAX counter advancing on inc, exposes next value and wrap
// Revision: 1.0
// ============================================================================
module wrap_counter #(
  parameter int WIDTH = 11,
  parameter int MAX   = 1343
) (
  input  logic             clk65MHz,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;

  always_comb begin
    wrap       = inc && (r_count == c_max);
    count_next = r_count;
    if (wrap) begin
      count_next = '0;
    end else if (inc) begin
      count_next = r_count + 1'b1;
    end
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= count_next;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : XGA raster timing source with line/frame strobes
// Revision: 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL
) (
  input  logic clk65MHz,
  input  logic rst,
  vga_if.out   vga_out_if,
  output logic line_start,
  output logic frame_start
);

  localparam int W = vga_pkg::COUNT_W;

  localparam logic [W-1:0] c_hblnk_start = W'(H_ACTIVE);
  localparam logic [W-1:0] c_hsync_start = W'(H_ACTIVE + H_FP);
  localparam logic [W-1:0] c_hsync_end   = W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [W-1:0] c_vblnk_start = W'(V_ACTIVE);
  localparam logic [W-1:0] c_vsync_start = W'(V_ACTIVE + V_FP);
  localparam logic [W-1:0] c_vsync_end   = W'(V_ACTIVE + V_FP + V_SYNC);

  logic [W-1:0] w_hcount;
  logic [W-1:0] w_hnext;
  logic [W-1:0] w_vcount;
  logic [W-1:0] w_vnext;
  logic         w_hwrap;
  logic         w_vwrap;

  logic r_hsync;
  logic r_vsync;
  logic r_hblnk;
  logic r_vblnk;
  logic r_line_start;
  logic r_frame_start;

  wrap_counter #(.WIDTH(W), .MAX(H_TOTAL - 1)) u_hcnt (
    .clk65MHz   (clk65MHz),
    .rst        (rst),
    .inc        (1'b1),
    .count      (w_hcount),
    .count_next (w_hnext),
    .wrap       (w_hwrap)
  );

  wrap_counter #(.WIDTH(W), .MAX(V_TOTAL - 1)) u_vcnt (
    .clk65MHz   (clk65MHz),
    .rst        (rst),
    .inc        (w_hwrap),
    .count      (w_vcount),
    .count_next (w_vnext),
    .wrap       (w_vwrap)
  );

  // Flags decode the next counts so they land alongside the counts they describe.
  // A wrap is the only way the next count becomes 0, so wraps double as strobes.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hblnk       <= (w_hnext >= c_hblnk_start);
      r_vblnk       <= (w_vnext >= c_vblnk_start);
      r_hsync       <= (w_hnext >= c_hsync_start) && (w_hnext < c_hsync_end);
      r_vsync       <= (w_vnext >= c_vsync_start) && (w_vnext < c_vsync_end);
      r_line_start  <= w_hwrap;
      r_frame_start <= w_vwrap;
    end
  end

  assign vga_out_if.hcount = w_hcount;
  assign vga_out_if.vcount = w_vcount;
  assign vga_out_if.hsync  = r_hsync;
  assign vga_out_if.vsync  = r_vsync;
  assign vga_out_if.hblnk  = r_hblnk;
  assign vga_out_if.vblnk  = r_vblnk;
  assign vga_out_if.rgb    = 12'h000;
  assign line_start        = r_line_start;
  assign frame_start       = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : reduced-raster and full-XGA instances vs arithmetic model
// Revision: 1.0
// ============================================================================
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HT = 25;
  localparam int S_VA = 8,  S_VF = 1, S_VS = 2, S_VT = 13;
  localparam int S_FRAME = S_HT * S_VT;

  logic clk65MHz = 1'b0;
  always #5 clk65MHz = ~clk65MHz;

  logic rst_s = 1'b1;
  logic rst_x = 1'b1;
  logic ls_s, fs_s, ls_x, fs_x;

  vga_if s_if ();
  vga_if x_if ();

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_TOTAL(S_HT),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_TOTAL(S_VT)
  ) dut_s (
    .clk65MHz    (clk65MHz),
    .rst         (rst_s),
    .vga_out_if  (s_if),
    .line_start  (ls_s),
    .frame_start (fs_s)
  );

  vga_timing_gen dut_x (
    .clk65MHz    (clk65MHz),
    .rst         (rst_x),
    .vga_out_if  (x_if),
    .line_start  (ls_x),
    .frame_start (fs_x)
  );

  typedef struct {
    int h; int v;
    bit hs; bit vs; bit hb; bit vb; bit ls; bit fs;
  } exp_t;

  // Expected raster state after n clocks since reset release (n = 0 is the reset state).
  function automatic exp_t model(input int n, input int ha, input int hf, input int hsw,
                                 input int ht, input int va, input int vf, input int vsw,
                                 input int vt);
    exp_t m;
    m.h  = n % ht;
    m.v  = (n / ht) % vt;
    m.hb = (m.h >= ha);
    m.vb = (m.v >= va);
    m.hs = (m.h >= ha + hf) && (m.h < ha + hf + hsw);
    m.vs = (m.v >= va + vf) && (m.v < va + vf + vsw);
    m.ls = (n > 0) && (m.h == 0);
    m.fs = (n > 0) && (m.h == 0) && (m.v == 0);
    return m;
  endfunction

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_dut(input string p, input exp_t e, input logic [10:0] h,
                           input logic [10:0] v, input logic hs, input logic vs,
                           input logic hb, input logic vb, input logic ls,
                           input logic fs, input logic [11:0] rgb, input int ht,
                           input int vt);
    check({p, "_hcount"}, 32'(h), 32'(e.h));
    check({p, "_vcount"}, 32'(v), 32'(e.v));
    check({p, "_hsync"}, 32'(hs), 32'(e.hs));
    check({p, "_vsync"}, 32'(vs), 32'(e.vs));
    check({p, "_hblnk"}, 32'(hb), 32'(e.hb));
    check({p, "_vblnk"}, 32'(vb), 32'(e.vb));
    check({p, "_line_start"}, 32'(ls), 32'(e.ls));
    check({p, "_frame_start"}, 32'(fs), 32'(e.fs));
    check({p, "_rgb"}, 32'(rgb), 32'd0);
    check({p, "_hrange"}, 32'(int'(h) < ht), 32'd1);
    check({p, "_vrange"}, 32'(int'(v) < vt), 32'd1);
  endtask

  int ns = 0;
  int nx = 0;
  bit collect = 1'b0;
  int fs_cnt_s = 0, ls_cnt_s = 0, vs_cyc_s = 0, first_fs_s = 0, hs_cyc_x = 0;

  task automatic tick(input logic rs, input logic rx);
    exp_t es, ex;
    rst_s = rs;
    rst_x = rx;
    @(posedge clk65MHz);
    #1;
    ns = rs ? 0 : ns + 1;
    nx = rx ? 0 : nx + 1;
    es = model(ns, S_HA, S_HF, S_HS, S_HT, S_VA, S_VF, S_VS, S_VT);
    ex = model(nx, H_ACTIVE, H_FP, H_SYNC, H_TOTAL, V_ACTIVE, V_FP, V_SYNC, V_TOTAL);
    check_dut("s", es, s_if.hcount, s_if.vcount, s_if.hsync, s_if.vsync, s_if.hblnk,
              s_if.vblnk, ls_s, fs_s, s_if.rgb, S_HT, S_VT);
    check_dut("x", ex, x_if.hcount, x_if.vcount, x_if.hsync, x_if.vsync, x_if.hblnk,
              x_if.vblnk, ls_x, fs_x, x_if.rgb, H_TOTAL, V_TOTAL);
    if (collect && ns >= 1 && ns <= 3 * S_FRAME) begin
      fs_cnt_s += int'(fs_s);
      ls_cnt_s += int'(ls_s);
      vs_cyc_s += int'(s_if.vsync);
      if (fs_s && first_fs_s == 0) first_fs_s = ns;
    end
    if (collect && nx >= 1 && nx <= 3 * H_TOTAL) hs_cyc_x += int'(x_if.hsync);
  endtask

  initial begin
    repeat (5) tick(1'b1, 1'b1);

    collect = 1'b1;
    repeat (4100) tick(1'b0, 1'b0);
    collect = 1'b0;

    check("s_frame_start_count", 32'(fs_cnt_s), 32'd3);
    check("s_line_start_count", 32'(ls_cnt_s), 32'(3 * S_VT));
    check("s_first_frame_start", 32'(first_fs_s), 32'(S_FRAME));
    check("s_vsync_cycles", 32'(vs_cyc_s), 32'(3 * S_VS * S_HT));
    check("x_hsync_cycles", 32'(hs_cyc_x), 32'(3 * H_SYNC));

    // Single-cycle reset on the XGA instance in the middle of a line.
    for (int i = 0; i < 2 * H_TOTAL && x_if.hcount != 11'd500; i++) tick(1'b0, 1'b0);
    check("x_reached_500", 32'(x_if.hcount), 32'd500);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Random run lengths with random reset pulses on both instances.
    for (int k = 0; k < 25; k++) begin
      int len;
      int rlen;
      logic rx;
      len  = int'($urandom_range(1, 400));
      rlen = int'($urandom_range(1, 3));
      rx   = ($urandom_range(0, 3) == 0);
      repeat (len) tick(1'b0, 1'b0);
      repeat (rlen) tick(1'b1, rx);
    end
    repeat (2 * S_FRAME) tick(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
